// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants shared by the fetch stage
package fetch_unit_pkg;
  localparam int xlen = 32;
  localparam logic [31:0] nop_instr = 32'h0000_0013;
  localparam logic [31:0] reset_pc = 32'h0000_0000;
  localparam int fq_depth = 2;
  localparam int instr_size = 4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: flushable FIFO of {pc, instr} entries with a registered head
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign dout = mem[head];
  // pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= pop ? head + AW'(1) : head;
      tail <= push ? tail + AW'(1) : tail;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage needs no reset: count gates every read
  always_ff @(posedge clk)
    if (push && !flush) mem[tail] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem requests, fetch queue and redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = xlen,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(reset_pc),
  parameter int FQ_DEPTH = fq_depth
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            chng2nop
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [XLEN-1:0] inc = XLEN'(instr_size);
  logic [XLEN-1:0] fetch_pc, resp_pc, last_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [XLEN+31:0] head;
  logic running, issue, accept, push, pop;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign issue = imem_req && imem_gnt;
  assign accept = imem_rvalid && outstanding != '0;
  assign push = accept && drop_cnt == '0 && !redirect_valid;
  assign pop = instr_valid && !stall && !redirect_valid;
  assign imem_req = running && !redirect_valid &&
                    ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FQ_DEPTH);
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr_out = instr_valid ? head[31:0] : nop_instr;
  assign pc_out = instr_valid ? head[XLEN+31:32] : last_pc;
  fetch_queue #(.W(XLEN + 32), .DEPTH(FQ_DEPTH)) u_q (
    .clk(clk),
    .nrst(nrst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({resp_pc, imem_rdata}),
    .dout(head),
    .count(count)
  );
  // PCs, credit and drop counters; a redirect replaces any pending drop count
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      running <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      last_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      chng2nop <= 1'b0;
    end else begin
      running <= 1'b1;
      chng2nop <= redirect_valid;
      last_pc <= pc_out;
      outstanding <= outstanding + CW'(issue) - CW'(accept);
      fetch_pc <= redirect_valid ? target : issue ? fetch_pc + inc : fetch_pc;
      resp_pc <= redirect_valid ? target : push ? resp_pc + inc : resp_pc;
      drop_cnt <= redirect_valid ? outstanding - CW'(accept) :
                  (accept && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
    end
endmodule
